// File: rtl/regs_pkg.sv
// Shared types and constants for the two-bank register file.
package regs_pkg;

    localparam int REG_W  = 16;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [REG_W-1:0] word_t;

    // Value the L bus floats to when nothing drives it (wired-AND idle level).
    localparam word_t L_IDLE = 16'hffff;

endpackage : regs_pkg

// File: rtl/regs_bank.sv
// One 4x16 register bank: async active-low clear, synchronous write on an
// active-low strobe, and a gated combinational read that idles high so
// several banks can be ANDed onto the same bus.
module regs_bank
    import regs_pkg::*;
(
    input  logic              clk_sys,
    input  logic              rst_,
    input  logic              wr_,
    input  logic              rd_,
    input  logic [ADDR_W-1:0] addr,
    input  word_t             w,
    output word_t             q
);

    word_t mem [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            word_t entry_reg;
            logic  hit;

            assign hit = (addr == ADDR_W'(gi));

            // Entry storage: cleared asynchronously, loaded when this entry is addressed and written.
            always_ff @(posedge clk_sys or negedge rst_) begin
                if (!rst_) begin
                    entry_reg <= '0;
                end else if (!wr_ && hit) begin
                    entry_reg <= w;
                end
            end

            assign mem[gi] = entry_reg;
        end
    endgenerate

    // Read is purely combinational so the bus follows address and strobe immediately.
    assign q = rd_ ? L_IDLE : mem[addr];

endmodule : regs_bank

// File: rtl/regs.sv
// Register file between the W bus and the L bus: banks N and W share the
// address, have independent strobes, and their read outputs are ANDed to
// model the open-collector L bus.
module regs
    import regs_pkg::*;
(
    input  logic  clk_sys,
    input  logic  rst_,
    input  word_t w,
    output word_t l,
    input  logic  ra,
    input  logic  rb,
    input  logic  czytrn_,
    input  logic  piszrn_,
    input  logic  czytrw_,
    input  logic  piszrw_
);

    logic [ADDR_W-1:0] addr;
    word_t             n_q;
    word_t             w_q;

    assign addr = {ra, rb};

    regs_bank u_bank_n (
        .clk_sys (clk_sys),
        .rst_    (rst_),
        .wr_     (piszrn_),
        .rd_     (czytrn_),
        .addr    (addr),
        .w       (w),
        .q       (n_q)
    );

    regs_bank u_bank_w (
        .clk_sys (clk_sys),
        .rst_    (rst_),
        .wr_     (piszrw_),
        .rd_     (czytrw_),
        .addr    (addr),
        .w       (w),
        .q       (w_q)
    );

    // Wired-AND: an idle bank contributes all ones, so it never masks the other.
    assign l = n_q & w_q;

endmodule : regs

// File: tb/tb_regs.sv
// Directed bench for the two-bank register file with a scoreboard queue.
module tb_regs;
    import regs_pkg::*;

    logic  clk_sys = 1'b0;
    logic  rst_;
    word_t w;
    word_t l;
    logic  ra, rb;
    logic  czytrn_, piszrn_, czytrw_, piszrw_;

    int errors = 0;
    int checks = 0;

    word_t exp_q [$];
    string tag_q [$];

    regs dut (
        .clk_sys (clk_sys),
        .rst_    (rst_),
        .w       (w),
        .l       (l),
        .ra      (ra),
        .rb      (rb),
        .czytrn_ (czytrn_),
        .piszrn_ (piszrn_),
        .czytrw_ (czytrw_),
        .piszrw_ (piszrw_)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic set_addr(input logic [1:0] a);
        {ra, rb} = a;
    endtask

    // Record the expected bus value for the stimulus just applied.
    task automatic push_exp(input string tag, input word_t v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    // Let the combinational path settle, then compare the oldest expectation.
    task automatic check_l();
        word_t e;
        string t;
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (l === e)
        else begin
            errors++;
            $error("FAIL %s: l=%h expected %h", t, l, e);
        end
        $display("check %-18s l=%h exp=%h", t, l, e);
    endtask

    task automatic expect_l(input string tag, input word_t v);
        push_exp(tag, v);
        check_l();
    endtask

    initial begin
        rst_ = 1'b0;
        w = 16'hbeef;
        set_addr(2'd1);
        czytrn_ = 1'b1; piszrn_ = 1'b1; czytrw_ = 1'b1; piszrw_ = 1'b1;
        #12;
        expect_l("reset_idle", 16'hffff);
        czytrn_ = 1'b0;
        expect_l("reset_n_zero", 16'h0000);
        czytrn_ = 1'b1; czytrw_ = 1'b0;
        expect_l("reset_w_zero", 16'h0000);
        czytrw_ = 1'b1;

        @(negedge clk_sys);
        rst_ = 1'b1;
        expect_l("idle_after_rst", 16'hffff);

        // N bank write with its read strobe high: bus stays idle
        piszrn_ = 1'b0;
        @(posedge clk_sys);
        expect_l("n_write_hidden", 16'hffff);
        @(negedge clk_sys);
        piszrn_ = 1'b1; czytrn_ = 1'b0;
        expect_l("n_read_beef", 16'hbeef);

        // W bank write, then isolation from N
        czytrn_ = 1'b1; w = 16'hdead; piszrw_ = 1'b0;
        @(posedge clk_sys);
        expect_l("w_write_hidden", 16'hffff);
        @(negedge clk_sys);
        piszrw_ = 1'b1; w = 16'h1111; czytrw_ = 1'b0;
        expect_l("w_read_dead", 16'hdead);
        czytrw_ = 1'b1; czytrn_ = 1'b0;
        expect_l("n_unchanged", 16'hbeef);

        // Dual read is the AND of both entries
        czytrw_ = 1'b0;
        expect_l("dual_read", 16'h9ead);
        czytrw_ = 1'b1;

        // Read during write: old value before the edge, new after
        w = 16'hcafe; piszrn_ = 1'b0;
        expect_l("rdw_before", 16'hbeef);
        @(posedge clk_sys);
        expect_l("rdw_after", 16'hcafe);
        @(negedge clk_sys);
        piszrn_ = 1'b1;

        // Addressing: fill N[0..3], read each back
        czytrn_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_addr(2'(i));
            w = 16'h1000 + 16'(i);
            piszrn_ = 1'b0;
            @(negedge clk_sys);
            piszrn_ = 1'b1;
        end
        czytrn_ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_addr(2'(i));
            push_exp($sformatf("addr_n%0d", i), 16'h1000 + 16'(i));
            check_l();
        end
        czytrn_ = 1'b1; czytrw_ = 1'b0;
        set_addr(2'd1);
        expect_l("w1_unchanged", 16'hdead);
        set_addr(2'd0);
        expect_l("w0_unchanged", 16'h0000);
        czytrw_ = 1'b1;

        // Dual write at addr 2
        @(negedge clk_sys);
        set_addr(2'd2); w = 16'ha5a5; piszrn_ = 1'b0; piszrw_ = 1'b0;
        @(negedge clk_sys);
        piszrn_ = 1'b1; piszrw_ = 1'b1; w = 16'h0000;
        czytrn_ = 1'b0;
        expect_l("dual_wr_n", 16'ha5a5);
        czytrn_ = 1'b1; czytrw_ = 1'b0;
        expect_l("dual_wr_w", 16'ha5a5);
        czytrw_ = 1'b1; czytrn_ = 1'b0;
        set_addr(2'd3);
        expect_l("n3_kept", 16'h1003);

        // Asynchronous reset between edges, write strobe held through it
        set_addr(2'd2);
        @(negedge clk_sys);
        #1;
        rst_ = 1'b0;
        expect_l("async_rst", 16'h0000);
        w = 16'hffff; piszrn_ = 1'b0; piszrw_ = 1'b0;
        @(posedge clk_sys);
        expect_l("rst_blocks_n", 16'h0000);
        czytrn_ = 1'b1; czytrw_ = 1'b0;
        expect_l("rst_blocks_w", 16'h0000);
        @(negedge clk_sys);
        piszrn_ = 1'b1; piszrw_ = 1'b1;
        rst_ = 1'b1;
        expect_l("post_rst_w", 16'h0000);
        czytrw_ = 1'b1;
        expect_l("post_rst_idle", 16'hffff);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regs
